apb_master_mux: RTL and testbench
=================================

Name: apb_master_mux

Overview:
- Parametrised APB master, the successor to the single-slave APB master.
- Accepts requests on a valid/ready handshake and drives one APB transfer at a time to one of NSEL slaves (one-hot psel).
- Returns read data and status on a one-cycle response pulse.
- Adds per-slave read/ready/error muxing, a decode-error path, an ACCESS-phase timeout watchdog and pprot pass-through.

Parameters:
- ADDR_W, 32, paddr/req_addr width.
- DATA_W, 32, data width; must be a multiple of 8.
- NSEL, 4, number of slaves (1..16); SEL_W = max(1, $clog2(NSEL)).
- TIMEOUT, 16, maximum ACCESS cycles before abort; 0 disables the watchdog.

Ports:
- pclk  in  1  bus clock, all logic on its rising edge
- preset  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  master can accept; high exactly when state==IDLE (combinational)
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_W  transfer address
- req_wdata  in  DATA_W  write data
- req_sel  in  SEL_W  target slave index
- req_prot  in  3  protection attributes
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data
- rsp_err  out  1  pslverr, decode error or timeout
- rsp_timeout  out  1  completion was a watchdog abort
- psel  out  NSEL  one-hot slave select
- penable  out  1  ACCESS phase
- pwrite  out  1  direction
- paddr  out  ADDR_W  address
- pwdata  out  DATA_W  write data
- pprot  out  3  protection
- prdata  in  NSEL*DATA_W  slave k occupies bits [k*DATA_W +: DATA_W]
- pready  in  NSEL  per-slave ready
- pslverr  in  NSEL  per-slave error

Behaviour:
- Clock and reset: one clock, pclk; reset preset is synchronous and active-high.
- Reset: all outputs 0, state IDLE. Asserting preset mid-transfer drops psel/penable at the next edge; no rsp_valid is produced for the aborted transfer.
- States: IDLE, SETUP, ACCESS. All outputs registered except req_ready.
- IDLE, on accept (req_valid & req_ready):
  - Latch paddr, pwrite, pwdata, pprot and the select index.
  - If req_sel < NSEL: psel[req_sel] <= 1, go to SETUP.
  - If req_sel >= NSEL (decode error): no bus activity; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0; stay IDLE.
- SETUP: psel held, penable <= 1, go to ACCESS. Fixed 1 cycle.
- ACCESS: the selected slave's pready, pslverr and prdata slice are used; all other slices are ignored.
  - pready=1: psel <= 0, penable <= 0, rsp_valid <= 1, rsp_err <= pslverr, rsp_timeout <= 0, go to IDLE.
  - rsp_rdata <= prdata slice on a read; 0 on a write or error-free write.
- Watchdog (TIMEOUT>0):
  - Counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - In the TIMEOUT-th such cycle: abort as a completion with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - pready=1 in the limit cycle wins; this is a normal completion.
- Throughput: zero-wait transfer = accept edge + 3 cycles. A new request may be accepted in the rsp_valid cycle, giving psel low for at least 1 cycle between transfers.
- Signal stability: paddr, pwrite, pwdata and pprot stay stable from accept until the next accept.
- Response outputs: rsp_rdata, rsp_err and rsp_timeout hold their value until the next completion. rsp_valid is 1 for exactly one cycle per accepted request.
- req_ready=0: request inputs are ignored.

Optional Feature:
- Macro APB_STRB_EN.
- Defined:
  - Adds ports req_strb in DATA_W/8 and pstrb out DATA_W/8.
  - pstrb latched from req_strb on a write accept; forced 0 on a read accept; reset value 0.
- Undefined: no strobe ports; all writes are full-word.

Test Plan:
- Write sel=2, addr=0x10, wdata=0xDEADBEEF, slave 2 pready tied 1 -> psel=4'b0100; penable high 1 cycle; rsp_valid 3 cycles after accept; rsp_err=0, rsp_rdata=0.
- Read sel=1, slave 1 prdata=0x12345678, pready low 3 ACCESS cycles, pslverr=1 -> rsp_rdata=0x12345678, rsp_err=1; slave 0/3 data ignored (driven 0xFFFFFFFF).
- Read sel=0, pready never asserted, TIMEOUT=16 -> penable high exactly 16 cycles, then rsp_err=1, rsp_timeout=1, psel=0.
- Request with req_sel=5, NSEL=4 -> psel stays 0; rsp_valid next cycle with rsp_err=1.
- Back-to-back writes addr 0x0 then 0x4, req_valid held -> second accepted in first rsp_valid cycle; psel low exactly 1 cycle between transfers.
- preset pulsed during ACCESS of a read -> next edge: psel=0, penable=0, no rsp_valid. With APB_STRB_EN: write strb=4'b0011 -> pstrb=4'b0011; a following read -> pstrb=0.

Source files
------------

// File: rtl/apb_master_mux.sv
// ---------------------------------------------------------------------------
// apb_master_mux
//
// APB master that drives one transfer at a time to one of NSEL slaves. The
// request side uses a valid/ready handshake and each accepted request ends
// with a single-cycle response pulse carrying read data and status.
//
// Parameters:
//   ADDR_W   address width
//   DATA_W   data width (multiple of 8)
//   NSEL     number of slaves, 1..16
//   TIMEOUT  maximum ACCESS cycles before the watchdog aborts (0 = off)
//
// Ports:
//   pclk, preset        clock, synchronous active-high reset
//   req_valid/req_ready request handshake (req_ready high only in IDLE)
//   req_write           1 = write, 0 = read
//   req_addr/req_wdata  transfer address and write data
//   req_sel             target slave index (>= NSEL is a decode error)
//   req_prot            protection attributes, passed to pprot
//   rsp_valid           one-cycle completion pulse
//   rsp_rdata           read data (0 for writes, decode errors, timeouts)
//   rsp_err             slave error, decode error or timeout
//   rsp_timeout         completion was a watchdog abort
//   psel/penable/pwrite/paddr/pwdata/pprot  APB master outputs
//   prdata/pready/pslverr  per-slave APB returns, slave k in slice k
//
// Optional feature (macro APB_STRB_EN):
//   Adds req_strb / pstrb. pstrb follows req_strb on a write accept and is
//   forced to 0 on a read accept. Without the macro all writes are full-word.
// ---------------------------------------------------------------------------
module apb_master_mux #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NSEL    = 4,
  parameter int TIMEOUT = 16,
  localparam int SEL_W  = (NSEL > 1) ? $clog2(NSEL) : 1
) (
  input  logic                   pclk,
  input  logic                   preset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  input  logic [SEL_W-1:0]       req_sel,
  input  logic [2:0]             req_prot,
`ifdef APB_STRB_EN
  input  logic [DATA_W/8-1:0]    req_strb,
  output logic [DATA_W/8-1:0]    pstrb,
`endif
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic                   rsp_timeout,
  output logic [NSEL-1:0]        psel,
  output logic                   penable,
  output logic                   pwrite,
  output logic [ADDR_W-1:0]      paddr,
  output logic [DATA_W-1:0]      pwdata,
  output logic [2:0]             pprot,
  input  logic [NSEL*DATA_W-1:0] prdata,
  input  logic [NSEL-1:0]        pready,
  input  logic [NSEL-1:0]        pslverr
);

  // The watchdog counts ACCESS cycles without pready; it only has to reach
  // TIMEOUT-1, because the TIMEOUT-th stalled cycle is the abort cycle.
  localparam int              WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [NSEL-1:0]   r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic [2:0]        r_pprot;
  logic              r_rspValid;
  logic [DATA_W-1:0] r_rspRdata;
  logic              r_rspErr;
  logic              r_rspTimeout;
  logic [WD_W-1:0]   r_wdCount;

  logic [NSEL-1:0]   w_pselNext;
  logic              w_penableNext;
  logic              w_pwriteNext;
  logic [ADDR_W-1:0] w_paddrNext;
  logic [DATA_W-1:0] w_pwdataNext;
  logic [2:0]        w_pprotNext;
  logic              w_rspValidNext;
  logic [DATA_W-1:0] w_rspRdataNext;
  logic              w_rspErrNext;
  logic              w_rspTimeoutNext;
  logic [WD_W-1:0]   w_wdCountNext;

`ifdef APB_STRB_EN
  logic [DATA_W/8-1:0] r_pstrb;
  logic [DATA_W/8-1:0] w_pstrbNext;
`endif

  logic [31:0]       w_selWide;
  logic              w_selInRange;
  logic [NSEL-1:0]   w_pselDecode;
  logic              w_slvReady;
  logic              w_slvErr;
  logic [DATA_W-1:0] w_slvRdata;
  logic              w_wdExpire;

  assign req_ready   = (r_state == ST_IDLE);

  assign psel        = r_psel;
  assign penable     = r_penable;
  assign pwrite      = r_pwrite;
  assign paddr       = r_paddr;
  assign pwdata      = r_pwdata;
  assign pprot       = r_pprot;
  assign rsp_valid   = r_rspValid;
  assign rsp_rdata   = r_rspRdata;
  assign rsp_err     = r_rspErr;
  assign rsp_timeout = r_rspTimeout;
`ifdef APB_STRB_EN
  assign pstrb       = r_pstrb;
`endif

  // Decode the requested index into a one-hot select. The index is widened
  // first so that the range check also covers NSEL values that are not a
  // power of two (the spare codes are decode errors).
  assign w_selWide    = 32'(req_sel);
  assign w_selInRange = (w_selWide < 32'(NSEL));

  always_comb begin
    w_pselDecode = '0;
    for (int k = 0; k < NSEL; k++) begin
      if (w_selWide == 32'(k)) begin
        w_pselDecode[k] = 1'b1;
      end
    end
  end

  // Return-path mux. psel stays one-hot for the whole transfer, so it is
  // used directly as an AND-OR mask: only the selected slave's ready, error
  // and data slice can reach the response logic.
  always_comb begin
    w_slvReady = 1'b0;
    w_slvErr   = 1'b0;
    w_slvRdata = '0;
    for (int k = 0; k < NSEL; k++) begin
      if (r_psel[k]) begin
        w_slvReady = w_slvReady | pready[k];
        w_slvErr   = w_slvErr   | pslverr[k];
        w_slvRdata = w_slvRdata | prdata[k*DATA_W +: DATA_W];
      end
    end
  end

  // The watchdog fires in the TIMEOUT-th stalled ACCESS cycle. A slave that
  // raises pready in that same cycle is checked first and wins.
  assign w_wdExpire = (TIMEOUT > 0) && (r_wdCount == WD_LIMIT);

  // Next-state and next-output logic. Bus attributes hold their value until
  // the next accept, response fields hold until the next completion, and
  // rsp_valid falls back to 0 unless a completion happens this cycle.
  always_comb begin
    w_stateNext      = r_state;
    w_pselNext       = r_psel;
    w_penableNext    = r_penable;
    w_pwriteNext     = r_pwrite;
    w_paddrNext      = r_paddr;
    w_pwdataNext     = r_pwdata;
    w_pprotNext      = r_pprot;
    w_rspValidNext   = 1'b0;
    w_rspRdataNext   = r_rspRdata;
    w_rspErrNext     = r_rspErr;
    w_rspTimeoutNext = r_rspTimeout;
    w_wdCountNext    = r_wdCount;
`ifdef APB_STRB_EN
    w_pstrbNext      = r_pstrb;
`endif

    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_pwriteNext = req_write;
          w_paddrNext  = req_addr;
          w_pwdataNext = req_wdata;
          w_pprotNext  = req_prot;
`ifdef APB_STRB_EN
          w_pstrbNext  = req_write ? req_strb : '0;
`endif
          if (w_selInRange) begin
            w_pselNext  = w_pselDecode;
            w_stateNext = ST_SETUP;
          end else begin
            // Decode error: no bus cycle, answer immediately from IDLE.
            w_rspValidNext   = 1'b1;
            w_rspErrNext     = 1'b1;
            w_rspTimeoutNext = 1'b0;
            w_rspRdataNext   = '0;
          end
        end
      end

      ST_SETUP: begin
        w_penableNext = 1'b1;
        w_wdCountNext = '0;
        w_stateNext   = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (w_slvReady) begin
          w_pselNext       = '0;
          w_penableNext    = 1'b0;
          w_rspValidNext   = 1'b1;
          w_rspErrNext     = w_slvErr;
          w_rspTimeoutNext = 1'b0;
          w_rspRdataNext   = r_pwrite ? '0 : w_slvRdata;
          w_stateNext      = ST_IDLE;
        end else if (w_wdExpire) begin
          w_pselNext       = '0;
          w_penableNext    = 1'b0;
          w_rspValidNext   = 1'b1;
          w_rspErrNext     = 1'b1;
          w_rspTimeoutNext = 1'b1;
          w_rspRdataNext   = '0;
          w_stateNext      = ST_IDLE;
        end else if (TIMEOUT > 0) begin
          w_wdCountNext = r_wdCount + WD_W'(1);
        end
      end

      default: begin
        w_pselNext    = '0;
        w_penableNext = 1'b0;
        w_stateNext   = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Output and datapath registers. Reset clears everything, which also
  // drops an in-flight transfer without producing a response for it.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_psel       <= '0;
      r_penable    <= 1'b0;
      r_pwrite     <= 1'b0;
      r_paddr      <= '0;
      r_pwdata     <= '0;
      r_pprot      <= '0;
      r_rspValid   <= 1'b0;
      r_rspRdata   <= '0;
      r_rspErr     <= 1'b0;
      r_rspTimeout <= 1'b0;
      r_wdCount    <= '0;
    end else begin
      r_psel       <= w_pselNext;
      r_penable    <= w_penableNext;
      r_pwrite     <= w_pwriteNext;
      r_paddr      <= w_paddrNext;
      r_pwdata     <= w_pwdataNext;
      r_pprot      <= w_pprotNext;
      r_rspValid   <= w_rspValidNext;
      r_rspRdata   <= w_rspRdataNext;
      r_rspErr     <= w_rspErrNext;
      r_rspTimeout <= w_rspTimeoutNext;
      r_wdCount    <= w_wdCountNext;
    end
  end

`ifdef APB_STRB_EN
  // Write strobes, registered alongside the other bus attributes.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_pstrb <= '0;
    end else begin
      r_pstrb <= w_pstrbNext;
    end
  end
`else
  // Without strobes every write covers the full data word, so there is no
  // extra state to keep here.
`endif

endmodule

// File: tb/tb_apb_master_mux.sv
// ---------------------------------------------------------------------------
// tb_apb_master_mux
//
// Bench for apb_master_mux (NSEL=4, TIMEOUT=16). A table of directed
// transfers and a set of random transfers are driven through one task that
// plays the selected slave, and the measured latency, ACCESS length and
// response are compared against expectations. A second instance with
// NSEL=5 provides a 3-bit req_sel, so that index 5 can be requested and
// must decode-error (a 2-bit index for NSEL=4 cannot encode 5).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_apb_master_mux;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int NSEL    = 4;
  localparam int TIMEOUT = 16;
  localparam int SEL_W   = 2;
  localparam int NSEL2   = 5;
  localparam int SEL_W2  = 3;

  logic                   pclk;
  logic                   preset;
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [ADDR_W-1:0]      req_addr;
  logic [DATA_W-1:0]      req_wdata;
  logic [SEL_W-1:0]       req_sel;
  logic [2:0]             req_prot;
  logic                   rsp_valid;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   rsp_err;
  logic                   rsp_timeout;
  logic [NSEL-1:0]        psel;
  logic                   penable;
  logic                   pwrite;
  logic [ADDR_W-1:0]      paddr;
  logic [DATA_W-1:0]      pwdata;
  logic [2:0]             pprot;
  logic [NSEL*DATA_W-1:0] prdata;
  logic [NSEL-1:0]        pready;
  logic [NSEL-1:0]        pslverr;
`ifdef APB_STRB_EN
  logic [DATA_W/8-1:0]    req_strb;
  logic [DATA_W/8-1:0]    pstrb;
`endif

  logic                    req_valid2;
  logic                    req_ready2;
  logic [SEL_W2-1:0]       req_sel2;
  logic                    rsp_valid2;
  logic [DATA_W-1:0]       rsp_rdata2;
  logic                    rsp_err2;
  logic                    rsp_timeout2;
  logic [NSEL2-1:0]        psel2;
  logic                    penable2;
  logic                    pwrite2;
  logic [ADDR_W-1:0]       paddr2;
  logic [DATA_W-1:0]       pwdata2;
  logic [2:0]              pprot2;
  logic [NSEL2*DATA_W-1:0] prdata2;
  logic [NSEL2-1:0]        pready2;
  logic [NSEL2-1:0]        pslverr2;
`ifdef APB_STRB_EN
  logic [DATA_W/8-1:0]     pstrb2;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  apb_master_mux #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSEL(NSEL), .TIMEOUT(TIMEOUT)
  ) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel),
    .req_prot(req_prot),
`ifdef APB_STRB_EN
    .req_strb(req_strb), .pstrb(pstrb),
`endif
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pprot(pprot),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  apb_master_mux #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSEL(NSEL2), .TIMEOUT(TIMEOUT)
  ) dut2 (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel2),
    .req_prot(req_prot),
`ifdef APB_STRB_EN
    .req_strb(req_strb), .pstrb(pstrb2),
`endif
    .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2),
    .rsp_timeout(rsp_timeout2), .psel(psel2), .penable(penable2),
    .pwrite(pwrite2), .paddr(paddr2), .pwdata(pwdata2), .pprot(pprot2),
    .prdata(prdata2), .pready(pready2), .pslverr(pslverr2)
  );

  // Slaves of the second instance always answer at once with fixed data.
  assign pready2  = '1;
  assign pslverr2 = '0;
  assign prdata2  = {NSEL2{32'h0BAD_F00D}};

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Hard time limit so the bench can never hang.
  initial begin
    #5ms;
    $display("[TB] FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "[TB] time limit");
  end

  typedef struct {
    logic        wr;
    int          sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  prot;
    int          waits;
    logic        serr;
    logic [31:0] rdata;
    logic        expErr;
    logic        expTo;
    logic [31:0] expRdata;
    int          expAccess;
    int          expLatency;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] got,
                             input logic [127:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Drives one request and acts as the selected slave: pready rises in the
  // (waits+1)-th ACCESS cycle. Unselected slaves drive random ready/error
  // and all-ones data that must be ignored. latency counts edges from the
  // accept edge to the first cycle with rsp_valid visible.
  task automatic applyStimulus(
    input logic wr, input int sel, input logic [31:0] addr,
    input logic [31:0] wdata, input logic [2:0] prot, input int waits,
    input logic serr, input logic [31:0] rdata,
    output int latency, output int accessCnt, output logic err,
    output logic to, output logic [31:0] rd, output logic busOk,
    output logic pulseOk);
    logic [NSEL-1:0] oneHot;
    int guard;
    oneHot = '0;
    oneHot[sel] = 1'b1;
    latency = -1; accessCnt = 0; err = 1'bx; to = 1'bx; rd = 'x;
    busOk = 1'b1; pulseOk = 1'b0;
    guard = 0;
    while (!req_ready && guard < 50) begin
      tick();
      guard++;
    end
    pready  = NSEL'($urandom);
    pready[sel] = 1'b0;
    pslverr = NSEL'($urandom);
    pslverr[sel] = serr;
    prdata  = '1;
    prdata[sel*DATA_W +: DATA_W] = rdata;
    req_write = wr; req_sel = SEL_W'(sel); req_addr = addr;
    req_wdata = wdata; req_prot = prot; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_addr  = ~addr;
    for (int e = 1; e <= 100; e++) begin
      if (psel !== oneHot || paddr !== addr || pwrite !== wr ||
          pwdata !== wdata || pprot !== prot) busOk = 1'b0;
      if (penable === 1'b1) begin
        accessCnt++;
        pready[sel] = (accessCnt == waits + 1);
      end
      tick();
      if (rsp_valid === 1'b1) begin
        latency = e;
        break;
      end
    end
    pready[sel] = 1'b0;
    if (latency > 0) begin
      if (psel !== '0 || penable !== 1'b0) busOk = 1'b0;
      err = rsp_err; to = rsp_timeout; rd = rsp_rdata;
      tick();
      pulseOk = (rsp_valid === 1'b0) && (rsp_rdata === rd) &&
                (rsp_err === err) && (rsp_timeout === to);
    end
  endtask

  // Reference expectations from the transfer rules: the slave stalls
  // `waits` ACCESS cycles; if that reaches TIMEOUT the watchdog aborts
  // after exactly TIMEOUT ACCESS cycles, otherwise the transfer takes
  // waits+1 ACCESS cycles. One SETUP cycle precedes ACCESS.
  task automatic modelTxn(input logic wr, input int waits, input logic serr,
                          input logic [31:0] rdata, output int expAccess,
                          output int expLatency, output logic expErr,
                          output logic expTo, output logic [31:0] expRdata);
    if (waits >= TIMEOUT) begin
      expAccess = TIMEOUT; expErr = 1'b1; expTo = 1'b1; expRdata = 0;
    end else begin
      expAccess = waits + 1; expErr = serr; expTo = 1'b0;
      expRdata = wr ? 32'h0 : rdata;
    end
    expLatency = expAccess + 1;
  endtask

  task automatic checkTxn(input string tag, input vec_t v);
    int lat, acc;
    logic err, to, busOk, pulseOk;
    logic [31:0] rd;
    applyStimulus(v.wr, v.sel, v.addr, v.wdata, v.prot, v.waits, v.serr,
                  v.rdata, lat, acc, err, to, rd, busOk, pulseOk);
    checkOutput({tag, "_latency"}, 128'(lat), 128'(v.expLatency));
    checkOutput({tag, "_access_cycles"}, 128'(acc), 128'(v.expAccess));
    checkOutput({tag, "_rsp_err"}, 128'(err), 128'(v.expErr));
    checkOutput({tag, "_rsp_timeout"}, 128'(to), 128'(v.expTo));
    checkOutput({tag, "_rsp_rdata"}, 128'(rd), 128'(v.expRdata));
    checkOutput({tag, "_bus_stable"}, 128'(busOk), 128'(1));
    checkOutput({tag, "_pulse_hold"}, 128'(pulseOk), 128'(1));
  endtask

  initial begin : main
    vec_t v;
    logic sawRsp;

    //              wr    sel addr   wdata         prot waits serr rdata         err   to    rdata         acc lat
    vecs[0] = '{1'b1, 2, 32'h10, 32'hDEADBEEF, 3'd0, 0,  1'b0, 32'h5555AAAA, 1'b0, 1'b0, 32'h0,        1,  2};
    vecs[1] = '{1'b0, 1, 32'h20, 32'h0,        3'd2, 3,  1'b1, 32'h12345678, 1'b1, 1'b0, 32'h12345678, 4,  5};
    vecs[2] = '{1'b0, 0, 32'h30, 32'h0,        3'd1, 99, 1'b0, 32'h77777777, 1'b1, 1'b1, 32'h0,        16, 17};
    vecs[3] = '{1'b0, 3, 32'h40, 32'h0,        3'd7, 15, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0, 32'hA5A5A5A5, 16, 17};
    vecs[4] = '{1'b1, 0, 32'h50, 32'h01020304, 3'd5, 2,  1'b1, 32'h99999999, 1'b1, 1'b0, 32'h0,        3,  4};
    vecs[5] = '{1'b0, 2, 32'h60, 32'h0,        3'd3, 0,  1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 32'hCAFEF00D, 1,  2};

    preset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_sel = '0; req_prot = '0; prdata = '0;
    pready = '0; pslverr = '0; req_valid2 = 1'b0; req_sel2 = '0;
`ifdef APB_STRB_EN
    req_strb = '0;
`endif
    repeat (3) tick();

    checkOutput("reset_outputs",
                {psel, penable, pwrite, paddr, pwdata, pprot, rsp_valid,
                 rsp_rdata, rsp_err, rsp_timeout}, '0);
    checkOutput("reset_req_ready", 128'(req_ready), 128'(1));
    preset = 1'b0;
    tick();

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      checkTxn($sformatf("vec%0d", i), vecs[i]);
    end

    // Random transfers against the reference rules.
    for (int i = 0; i < 40; i++) begin
      v.wr    = 1'($urandom);
      v.sel   = int'($urandom_range(0, NSEL - 1));
      v.addr  = $urandom;
      v.wdata = $urandom;
      v.prot  = 3'($urandom);
      v.waits = int'($urandom_range(0, 20));
      v.serr  = 1'($urandom);
      v.rdata = $urandom;
      modelTxn(v.wr, v.waits, v.serr, v.rdata, v.expAccess, v.expLatency,
               v.expErr, v.expTo, v.expRdata);
      checkTxn($sformatf("rnd%0d", i), v);
    end

    // Decode error on the NSEL=5 instance: first a good read to slave 4 so
    // rsp_rdata is non-zero, then index 5 must answer next cycle with an
    // error, zero data and no bus activity.
    req_write = 1'b0; req_addr = 32'h40; req_prot = 3'd2;
    req_sel2 = 3'd4; req_valid2 = 1'b1;
    tick();
    req_valid2 = 1'b0;
    checkOutput("dec_good_psel", 128'(psel2), 128'(5'b10000));
    repeat (2) tick();
    checkOutput("dec_good_rsp", {rsp_valid2, rsp_err2, rsp_rdata2},
                {1'b1, 1'b0, 32'h0BADF00D});
    tick();
    req_write = 1'b1; req_addr = 32'h55; req_wdata = 32'h11112222;
    req_prot = 3'd5; req_sel2 = 3'd5; req_valid2 = 1'b1;
    tick();
    req_valid2 = 1'b0;
    checkOutput("dec_err_rsp", {rsp_valid2, rsp_err2, rsp_timeout2, rsp_rdata2},
                {1'b1, 1'b1, 1'b0, 32'h0});
    checkOutput("dec_err_nobus", {psel2, penable2, req_ready2},
                {5'b0, 1'b0, 1'b1});
    checkOutput("dec_err_latched", {pwrite2, pprot2, pwdata2, paddr2},
                {1'b1, 3'd5, 32'h11112222, 32'h55});
    tick();
    checkOutput("dec_err_after", {rsp_valid2, rsp_err2, psel2},
                {1'b0, 1'b1, 5'b0});

    // Back-to-back writes with req_valid held: the second request is taken
    // in the first response cycle, leaving psel low for one cycle.
    pready = '1; pslverr = '0; prdata = '0;
    req_write = 1'b1; req_sel = 2'd0; req_addr = 32'h0; req_wdata = 32'hA1;
    req_prot = 3'd0; req_valid = 1'b1;
    tick();
    req_addr = 32'h4; req_wdata = 32'hB2;
    checkOutput("b2b_first_setup", {psel, paddr}, {4'b0001, 32'h0});
    repeat (2) tick();
    checkOutput("b2b_first_rsp", {rsp_valid, req_ready, psel},
                {1'b1, 1'b1, 4'b0000});
    tick();
    req_valid = 1'b0;
    checkOutput("b2b_second_setup", {psel, paddr, pwdata, rsp_valid},
                {4'b0001, 32'h4, 32'hB2, 1'b0});
    repeat (2) tick();
    checkOutput("b2b_second_rsp", {rsp_valid, rsp_err, rsp_rdata},
                {1'b1, 1'b0, 32'h0});
    tick();

    // Reset during ACCESS of a read: bus drops at the next edge and the
    // aborted transfer never produces a response.
    pready = '0; req_write = 1'b0; req_sel = 2'd1; req_addr = 32'h80;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (2) tick();
    checkOutput("rst_mid_access", {psel, penable}, {4'b0010, 1'b1});
    preset = 1'b1;
    tick();
    preset = 1'b0;
    checkOutput("rst_mid_dropped", {psel, penable, rsp_valid},
                {4'b0000, 1'b0, 1'b0});
    pready = '1;
    sawRsp = 1'b0;
    repeat (4) begin
      tick();
      if (rsp_valid === 1'b1 || psel !== '0) sawRsp = 1'b1;
    end
    checkOutput("rst_mid_no_rsp", 128'(sawRsp), 128'(0));

`ifdef APB_STRB_EN
    // Strobes follow a write and are cleared by a read.
    req_write = 1'b1; req_sel = 2'd0; req_addr = 32'h100;
    req_strb = 4'b0011; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    checkOutput("strb_write", 128'(pstrb), 128'(4'b0011));
    repeat (2) tick();
    req_write = 1'b0; req_strb = 4'b1111; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    checkOutput("strb_read", 128'(pstrb), 128'(4'b0000));
    repeat (3) tick();
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
